mcp3208_emul: RTL

- Synthesizable responder model of the MCP3208 8-channel 12-bit SPI ADC.
- Decodes the four-wire ADC protocol (CS, CLK, DIN in; DOUT out) and returns 12-bit samples taken from a parallel input bus.
- Used for FPGA-internal loopback and bench verification of the ADC receiver, and to emulate the ADC on boards without the chip fitted.
- All pins are oversampled in the single `clock` domain.

---
 rtl/mcp3208_emul.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/mcp3208_emul.sv
// MCP3208 SPI ADC responder: decodes start/SGL/D2..D0 and returns a 12-bit sample
// from sample_flat. All pins are oversampled in the clock domain (clock >= 8x SPI CLK).
module mcp3208_emul #(
    parameter bit LSB_TAIL = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        CS,
    input  logic        CLK,
    input  logic        DIN,
    output logic        DOUT,
    output logic        DOUT_oe,
    input  logic [95:0] sample_flat,
    output logic        conv_strobe,
    output logic [2:0]  conv_chan,
    output logic        conv_sgl,
    output logic        abort,
    output logic        busy
);
    // IDLE: CS high | WAIT_START: skip leading zeros | CMD: SGL,D2..D0
    // SAMPLE: sample period + null bit | MSB: B11..B0 | TAIL: LSB-first echo or zeros
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_START, S_CMD, S_SAMPLE, S_MSB, S_TAIL
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_cs_s1, r_cs_s2, r_clk_s1, r_clk_s2, r_clk_d, r_din_s1, r_din_s2;
    logic        w_rise, w_fall;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [2:0]  r_cmd, w_cmd_nxt;
    logic [11:0] r_sample, w_sample_nxt;
    logic        r_dout, w_dout_nxt;
    logic        r_oe, w_oe_nxt;
    logic        r_strobe, w_strobe_nxt;
    logic        r_abort, w_abort_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_sgl, w_sgl_nxt;
    logic [2:0]  r_chan, w_chan_nxt;
    logic [2:0]  w_cmd_chan;
    logic [6:0]  w_base;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cs_s1  <= 1'b1;
            r_cs_s2  <= 1'b1;
            r_clk_s1 <= 1'b0;
            r_clk_s2 <= 1'b0;
            r_clk_d  <= 1'b0;
            r_din_s1 <= 1'b0;
            r_din_s2 <= 1'b0;
        end else begin
            r_cs_s1  <= CS;
            r_cs_s2  <= r_cs_s1;
            r_clk_s1 <= CLK;
            r_clk_s2 <= r_clk_s1;
            r_clk_d  <= r_clk_s2;
            r_din_s1 <= DIN;
            r_din_s2 <= r_din_s1;
        end
    end

    assign w_rise     = r_clk_s2 & ~r_clk_d;
    assign w_fall     = ~r_clk_s2 & r_clk_d;
    assign w_cmd_chan = {r_cmd[1:0], r_din_s2};
    assign w_base     = 7'(w_cmd_chan) * 7'd12;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_cmd_nxt    = r_cmd;
        w_sample_nxt = r_sample;
        w_dout_nxt   = r_dout;
        w_oe_nxt     = r_oe;
        w_busy_nxt   = r_busy;
        w_sgl_nxt    = r_sgl;
        w_chan_nxt   = r_chan;
        w_strobe_nxt = 1'b0;
        w_abort_nxt  = 1'b0;
        // CS release outranks any CLK edge detected in the same cycle
        if (r_state != S_IDLE && r_cs_s2) begin
            w_state_nxt = S_IDLE;
            w_oe_nxt    = 1'b0;
            w_dout_nxt  = 1'b0;
            w_busy_nxt  = 1'b0;
            w_abort_nxt = (r_state == S_CMD) || (r_state == S_SAMPLE) || (r_state == S_MSB);
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!r_cs_s2) begin
                        w_state_nxt = S_WAIT_START;
                        w_busy_nxt  = 1'b1;
                    end
                end
                S_WAIT_START: begin
                    if (w_rise && r_din_s2) begin
                        w_state_nxt = S_CMD;
                        w_cnt_nxt   = 4'd0;
                    end
                end
                S_CMD: begin
                    if (w_rise) begin
                        w_cmd_nxt = {r_cmd[1:0], r_din_s2};
                        w_cnt_nxt = r_cnt + 4'd1;
                        if (r_cnt == 4'd3) begin
                            w_sample_nxt = sample_flat[w_base +: 12];
                            w_strobe_nxt = 1'b1;
                            w_chan_nxt   = w_cmd_chan;
                            w_sgl_nxt    = r_cmd[2];
                            w_state_nxt  = S_SAMPLE;
                            w_cnt_nxt    = 4'd0;
                        end
                    end
                end
                S_SAMPLE: begin
                    if (w_rise) begin
                        w_cnt_nxt = 4'd1;
                    end else if (w_fall && r_cnt == 4'd1) begin
                        w_dout_nxt  = 1'b0;
                        w_oe_nxt    = 1'b1;
                        w_state_nxt = S_MSB;
                        w_cnt_nxt   = 4'd0;
                    end
                end
                S_MSB: begin
                    if (w_fall) begin
                        w_dout_nxt = r_sample[4'd11 - r_cnt];
                        w_cnt_nxt  = r_cnt + 4'd1;
                        if (r_cnt == 4'd11) begin
                            w_state_nxt = S_TAIL;
                            w_cnt_nxt   = 4'd0;
                        end
                    end
                end
                S_TAIL: begin
                    if (w_fall) begin
                        if (LSB_TAIL && r_cnt < 4'd11) begin
                            w_dout_nxt = r_sample[r_cnt + 4'd1];
                            w_cnt_nxt  = r_cnt + 4'd1;
                        end else begin
                            w_dout_nxt = 1'b0;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt    <= 4'd0;
            r_cmd    <= 3'd0;
            r_sample <= 12'd0;
            r_dout   <= 1'b0;
            r_oe     <= 1'b0;
            r_strobe <= 1'b0;
            r_abort  <= 1'b0;
            r_busy   <= 1'b0;
            r_sgl    <= 1'b0;
            r_chan   <= 3'd0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_cmd    <= w_cmd_nxt;
            r_sample <= w_sample_nxt;
            r_dout   <= w_dout_nxt;
            r_oe     <= w_oe_nxt;
            r_strobe <= w_strobe_nxt;
            r_abort  <= w_abort_nxt;
            r_busy   <= w_busy_nxt;
            r_sgl    <= w_sgl_nxt;
            r_chan   <= w_chan_nxt;
        end
    end

    assign DOUT        = r_dout & r_oe;
    assign DOUT_oe     = r_oe;
    assign conv_strobe = r_strobe;
    assign conv_chan   = r_chan;
    assign conv_sgl    = r_sgl;
    assign abort       = r_abort;
    assign busy        = r_busy;
endmodule
